// File: rtl/vec_a_load_ctrl_if.sv
// rtl/vec_a_load_ctrl_if.sv - control, element stream and register-file write signals of the vector-A loader
interface vec_a_load_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 34
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic              vec_valid;
  logic [ADDR_W:0]   vec_len;
  logic              busy;
  logic              cons_done;

  // Environment side: drives start/len/stream/release, observes writes and status.
  modport master (
    output start, len, in_valid, in_data, cons_done,
    input  in_ready, rf_w_en, rf_w_addr, rf_w_data, vec_valid, vec_len, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, cons_done,
    output in_ready, rf_w_en, rf_w_addr, rf_w_data, vec_valid, vec_len, busy
  );
endinterface

// File: rtl/vec_a_load_ctrl.sv
// rtl/vec_a_load_ctrl.sv - fills the vector-A register file from an element stream and holds it for the consumer
module vec_a_load_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 34
) (
  input  logic             clk,
  input  logic             rst,
  vec_a_load_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   vec_len_q, vec_len_d;
  logic              rf_w_en_q, rf_w_en_d;
  logic [ADDR_W-1:0] rf_w_addr_q, rf_w_addr_d;
  logic [DATA_W-1:0] rf_w_data_q, rf_w_data_d;
  logic              vec_valid_q, vec_valid_d;
  logic              hs;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    vec_len_d   = vec_len_q;
    rf_w_en_d   = 1'b0;
    rf_w_addr_d = rf_w_addr_q;
    rf_w_data_d = rf_w_data_q;
    hs          = bus.in_valid && (state_q == S_LOAD);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Zero or oversize lengths mean a full vector.
          vec_len_d = (bus.len == '0 || bus.len > DEPTH_L) ? DEPTH_L : bus.len;
          count_d   = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs) begin
          rf_w_en_d   = 1'b1;
          rf_w_addr_d = count_q[ADDR_W-1:0];
          rf_w_data_d = bus.in_data;
          count_d     = count_q + ONE_L;
          if (count_q == vec_len_q - ONE_L) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // A start arriving with the release is dropped; only the release counts.
        if (bus.cons_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    vec_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      vec_len_q   <= '0;
      rf_w_en_q   <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      vec_len_q   <= vec_len_d;
      rf_w_en_q   <= rf_w_en_d;
      rf_w_addr_q <= rf_w_addr_d;
      rf_w_data_q <= rf_w_data_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.rf_w_en   = rf_w_en_q;
  assign bus.rf_w_addr = rf_w_addr_q;
  assign bus.rf_w_data = rf_w_data_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.vec_len   = vec_len_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vec_a_load_ctrl.sv
// tb/tb_vec_a_load_ctrl.sv - directed bench with a write scoreboard for vec_a_load_ctrl
module tb_vec_a_load_ctrl;

  typedef struct {
    logic [2:0]  addr;
    logic [33:0] data;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  int   s0;
  wr_t  sb[$];

  vec_a_load_ctrl_if #(.ADDR_W(3), .DATA_W(34)) bus_if ();

  vec_a_load_ctrl #(.DEPTH(8), .ADDR_W(3), .DATA_W(34)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write must match the oldest outstanding accept, one cycle later.
  always @(negedge clk) begin
    if (bus_if.rf_w_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(bus_if.rf_w_addr), 64'hdead);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(bus_if.rf_w_addr), 64'(e.addr));
        check("wr_data", 64'(bus_if.rf_w_data), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [3:0] l);
    bus_if.start = 1'b1;
    bus_if.len   = l;
    step();
    bus_if.start = 1'b0;
    bus_if.len   = 4'd0;
  endtask

  task automatic send(input logic [33:0] d, input logic [2:0] a);
    check("send_in_ready", 64'(bus_if.in_ready), 64'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    sb.push_back('{addr: a, data: d, cyc: cyc + 1});
    step();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic finish_load(input logic [3:0] l);
    check("drain_in_ready", 64'(bus_if.in_ready), 64'd0);
    check("drain_w_en", 64'(bus_if.rf_w_en), 64'd1);
    check("drain_vec_valid", 64'(bus_if.vec_valid), 64'd0);
    step();
    check("hold_vec_valid", 64'(bus_if.vec_valid), 64'd1);
    check("hold_vec_len", 64'(bus_if.vec_len), 64'(l));
    check("hold_busy", 64'(bus_if.busy), 64'd1);
  endtask

  task automatic release_vec();
    bus_if.cons_done = 1'b1;
    step();
    bus_if.cons_done = 1'b0;
    check("rel_vec_valid", 64'(bus_if.vec_valid), 64'd0);
    check("rel_busy", 64'(bus_if.busy), 64'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.len = 4'd0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data = 34'd0;
    bus_if.cons_done = 1'b0;
    bubble(2);

    check("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    check("rst_w_en", 64'(bus_if.rf_w_en), 64'd0);
    check("rst_w_addr", 64'(bus_if.rf_w_addr), 64'd0);
    check("rst_w_data", 64'(bus_if.rf_w_data), 64'd0);
    check("rst_vec_valid", 64'(bus_if.vec_valid), 64'd0);
    check("rst_vec_len", 64'(bus_if.vec_len), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    rst = 1'b0;
    bubble(1);

    // Full back-to-back load of 8.
    s0 = cyc;
    start_load(4'd8);
    check("full_busy", 64'(bus_if.busy), 64'd1);
    check("full_vec_len", 64'(bus_if.vec_len), 64'd8);
    for (int i = 0; i < 8; i++) send(34'h3_0000_0000 + 34'(i), 3'(i));
    finish_load(4'd8);
    check("full_vv_cycle", 64'(cyc - s0), 64'd10);

    // Stream and start while holding are ignored.
    bus_if.in_valid = 1'b1;
    bus_if.in_data = 34'h1_2345_6789;
    step();
    check("hold_in_ready", 64'(bus_if.in_ready), 64'd0);
    step();
    bus_if.in_valid = 1'b0;
    start_load(4'd3);
    check("hold_start_len", 64'(bus_if.vec_len), 64'd8);
    check("hold_start_vv", 64'(bus_if.vec_valid), 64'd1);
    release_vec();

    // len=0 maps to a full vector, reloading from address 0.
    start_load(4'd0);
    check("len0_vec_len", 64'(bus_if.vec_len), 64'd8);
    for (int i = 0; i < 8; i++) send(34'($urandom) ^ {2'b10, 32'h0}, 3'(i));
    finish_load(4'd8);
    release_vec();

    // len=3, then start coincident with release.
    start_load(4'd3);
    for (int i = 0; i < 3; i++) send(34'h2_0000_0100 + 34'(i), 3'(i));
    finish_load(4'd3);
    bus_if.start = 1'b1;
    bus_if.len = 4'd5;
    bus_if.cons_done = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.cons_done = 1'b0;
    check("sim_busy", 64'(bus_if.busy), 64'd0);
    check("sim_vec_valid", 64'(bus_if.vec_valid), 64'd0);
    step();
    check("sim_no_load", 64'(bus_if.busy), 64'd0);
    check("sim_in_ready", 64'(bus_if.in_ready), 64'd0);

    // len=4 with bubbles; cons_done during LOAD has no effect.
    start_load(4'd4);
    for (int i = 0; i < 4; i++) begin
      send(34'h0_ABCD_0000 + 34'(i * 7), 3'(i));
      if (i < 3) begin
        bus_if.cons_done = (i == 1);
        step();
        bus_if.cons_done = 1'b0;
        check("bub_busy", 64'(bus_if.busy), 64'd1);
        check("bub_w_en", 64'(bus_if.rf_w_en), 64'd0);
        step();
      end
    end
    finish_load(4'd4);
    release_vec();

    // Reset partway through a load of 8.
    start_load(4'd8);
    for (int i = 0; i < 3; i++) send(34'h1_0000_0000 + 34'(i), 3'(i));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus_if.busy), 64'd0);
    check("mid_rst_w_en", 64'(bus_if.rf_w_en), 64'd0);
    check("mid_rst_w_addr", 64'(bus_if.rf_w_addr), 64'd0);
    check("mid_rst_vec_len", 64'(bus_if.vec_len), 64'd0);
    check("mid_rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    bubble(2);
    check("mid_rst_vec_valid", 64'(bus_if.vec_valid), 64'd0);
    rst = 1'b0;
    bubble(1);
    start_load(4'd2);
    for (int i = 0; i < 2; i++) send(34'h0_5555_0000 + 34'(i), 3'(i));
    finish_load(4'd2);
    release_vec();

    bubble(2);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
